uart_rx_sampler: RTL and testbench

//  Oversampling UART receiver front end: synchronises i_rx, detects and qualifies start bits, majority-votes each bit.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler_if.sv | 25 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_sampler.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// elaboration-time baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded clk/(baud*oversample), clamped so the tick counter always has two states.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    int den;
    int div;
    den = baud * oversample;
    div = (clk_freq + den / 2) / den;
    return (div < 2) ? 2 : div;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side character interface between the UART sampler and the RX FIFO.
interface uart_rx_sampler_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  // Handshake: o_data_valid is a one-cycle push with no ready/back-pressure;
  // o_data and both error flags are meaningful only in that cycle and are held
  // afterwards. o_break is a separate one-cycle pulse never paired with o_data_valid.
  logic                 o_data_valid;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_parity_error;
  logic                 o_frame_error;
  logic                 o_break;
  rx_state_t            o_dbg_state;

  modport master (
    output o_data_valid, o_data, o_parity_error, o_frame_error, o_break, o_dbg_state
  );

  modport slave (
    input o_data_valid, o_data, o_parity_error, o_frame_error, o_break, o_dbg_state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses o_tick on the last count.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    if (i_restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end: synchronises the line, qualifies start
// bits, majority-votes each bit and deframes characters, parity, framing and break.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_rx,
  uart_rx_sampler_if.master rx_if
);

  localparam int            DIV       = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int            SW        = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_MID_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  rx_state_t state_q, state_d;

  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_fall;
  logic tick;
  logic restart;

  logic [SW-1:0]        s_q, s_d, s_nxt;
  logic                 smp_lo_q, smp_lo_d;
  logic                 smp_mid_q, smp_mid_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 stop_err_q, stop_err_d;
  logic                 par_bit_q, par_bit_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  logic vote_now;
  logic vote;
  logic stop_bad;
  logic par_xor;
  logic par_err;

  // Two-flop synchroniser plus one history flop for edge detection; idle-high reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~sync2_q;
  assign restart = (state_q == RX_IDLE) & rx_fall;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_restart (restart),
    .o_tick    (tick)
  );

  // Sample index s advances on each tick; s == k means the k-th sample of the bit.
  assign s_nxt    = (s_q == S_LAST) ? '0 : s_q + SW'(1);
  assign vote_now = tick & (s_nxt == S_MID_HI);
  assign vote     = (smp_lo_q & smp_mid_q) | (smp_lo_q & sync2_q) | (smp_mid_q & sync2_q);
  assign stop_bad = stop_err_q | ~vote;

  assign par_xor = ^{shift_q, par_bit_q};
  assign par_err = (PARITY == PARITY_ODD)  ? ~par_xor :
                   (PARITY == PARITY_EVEN) ?  par_xor : 1'b0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All bit-level transitions happen at the mid-bit vote, so after a good stop
  // bit the receiver is already idle for the next start edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: begin
        if (rx_fall) state_d = RX_START;
      end
      RX_START: begin
        if (vote_now) state_d = vote ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (vote_now && (bit_cnt_q == BIT_LAST)) state_d = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (vote_now) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (vote_now && (stop_cnt_q == STOP_LAST)) state_d = stop_bad ? RX_WAIT_IDLE : RX_IDLE;
      end
      RX_WAIT_IDLE: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    s_d        = s_q;
    smp_lo_d   = smp_lo_q;
    smp_mid_d  = smp_mid_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    stop_err_d = stop_err_q;
    par_bit_d  = par_bit_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    brk_d      = 1'b0;

    if (state_q == RX_IDLE) begin
      s_d        = '0;
      bit_cnt_d  = '0;
      stop_cnt_d = '0;
      stop_err_d = 1'b0;
      par_bit_d  = 1'b0;
    end else if (tick) begin
      s_d = s_nxt;
      if (s_nxt == S_MID_LO) smp_lo_d  = sync2_q;
      if (s_nxt == S_MID)    smp_mid_d = sync2_q;
    end

    if (vote_now) begin
      case (state_q)
        RX_DATA: begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        RX_PARITY: begin
          par_bit_d = vote;
        end
        RX_STOP: begin
          stop_err_d = stop_bad;
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == STOP_LAST) begin
            // An all-zero frame with a low stop is a held-low line, not a character.
            if (!stop_bad || (shift_q != '0) || par_bit_q) begin
              valid_d = 1'b1;
              data_d  = shift_q;
              perr_d  = par_err;
              ferr_d  = stop_bad;
            end else begin
              brk_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_q        <= '0;
      smp_lo_q   <= 1'b1;
      smp_mid_q  <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      stop_err_q <= 1'b0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      s_q        <= s_d;
      smp_lo_q   <= smp_lo_d;
      smp_mid_q  <= smp_mid_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      stop_err_q <= stop_err_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_if.o_data_valid   = valid_q;
  assign rx_if.o_data         = data_q;
  assign rx_if.o_parity_error = perr_q;
  assign rx_if.o_frame_error  = ferr_q;
  assign rx_if.o_break        = brk_q;
  assign rx_if.o_dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8N1 instance (a) and 8E1 instance (b)
// with a scoreboard of expected {frame_error, parity_error, data} words.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int BIT      = 160;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;

  always #5 clk = ~clk;

  uart_rx_sampler_if #(.DATA_BITS(8)) if_a ();
  uart_rx_sampler_if #(.DATA_BITS(8)) if_b ();

  uart_rx_sampler #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_NONE)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .i_rx(rx_a), .rx_if(if_a)
  );

  uart_rx_sampler #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_EVEN)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .i_rx(rx_b), .rx_if(if_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [9:0] exp_a_q[$];
  logic [9:0] exp_b_q[$];

  int valid_a_cnt = 0;
  int valid_b_cnt = 0;
  int brk_a_cnt   = 0;
  int brk_b_cnt   = 0;
  int last_valid_a_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every o_data_valid pops one expected {ferr, perr, data} word.
  always @(negedge clk) begin
    logic [9:0] got;
    logic [9:0] exp;
    if (if_a.o_data_valid) begin
      valid_a_cnt++;
      last_valid_a_cyc = cyc;
      got = {if_a.o_frame_error, if_a.o_parity_error, if_a.o_data};
      checks++;
      assert (exp_a_q.size() != 0)
      else begin errors++; $error("FAIL a_unexpected_pulse: got %h, required no pulse", got); end
      if (exp_a_q.size() != 0) begin
        exp = exp_a_q.pop_front();
        checks++;
        assert (got === exp)
        else begin errors++; $error("FAIL a_char: got ferr/perr/data %b/%b/%h, required %b/%b/%h",
                                    got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]); end
      end
    end
    if (if_b.o_data_valid) begin
      valid_b_cnt++;
      got = {if_b.o_frame_error, if_b.o_parity_error, if_b.o_data};
      checks++;
      assert (exp_b_q.size() != 0)
      else begin errors++; $error("FAIL b_unexpected_pulse: got %h, required no pulse", got); end
      if (exp_b_q.size() != 0) begin
        exp = exp_b_q.pop_front();
        checks++;
        assert (got === exp)
        else begin errors++; $error("FAIL b_char: got ferr/perr/data %b/%b/%h, required %b/%b/%h",
                                    got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]); end
      end
    end
    if (if_a.o_break) brk_a_cnt++;
    if (if_b.o_break) brk_b_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin errors++; $error("FAIL %s: got %0h, required %0h", tag, got, exp); end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop, input int blen);
    drive_bit(sel, 1'b0, blen);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], blen);
    if (has_par) drive_bit(sel, par, blen);
    drive_bit(sel, stop, blen);
  endtask

  initial begin
    int start_cyc;
    int lat;
    int v0;
    int b0;
    logic [7:0] partial;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_data",  32'(if_a.o_data), 32'h0);
    chk("rst_valid", 32'(if_a.o_data_valid), 32'h0);
    chk("rst_perr",  32'(if_a.o_parity_error), 32'h0);
    chk("rst_ferr",  32'(if_a.o_frame_error), 32'h0);
    chk("rst_break", 32'(if_a.o_break), 32'h0);
    chk("rst_state", 32'(if_a.o_dbg_state), 32'(RX_IDLE));
    n_rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // 1: back-to-back 0x55, 0xA3 with first-pulse latency
    start_cyc = cyc;
    exp_a_q.push_back({1'b0, 1'b0, 8'h55});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, BIT);
    lat = last_valid_a_cyc - start_cyc;
    checks++;
    assert (lat >= 1510 && lat <= 1534)
    else begin errors++; $error("FAIL t1_latency: got %0d cycles, required 1510..1534", lat); end
    exp_a_q.push_back({1'b0, 1'b0, 8'hA3});
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    chk("t1_valid_count", 32'(valid_a_cnt), 32'd2);

    // 2: short and 70-cycle glitches are false starts
    v0 = valid_a_cnt;
    b0 = brk_a_cnt;
    drive_bit(1'b0, 1'b0, 3);
    drive_bit(1'b0, 1'b1, 2 * BIT);
    drive_bit(1'b0, 1'b0, 70);
    drive_bit(1'b0, 1'b1, 2 * BIT);
    chk("t2_no_valid", 32'(valid_a_cnt), 32'(v0));
    chk("t2_no_break", 32'(brk_a_cnt), 32'(b0));
    chk("t2_state_idle", 32'(if_a.o_dbg_state), 32'(RX_IDLE));
    exp_a_q.push_back({1'b0, 1'b0, 8'h12});
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    chk("t2_valid_after", 32'(valid_a_cnt), 32'(v0 + 1));

    // 3: even parity on instance b, wrong then right parity bit
    exp_b_q.push_back({1'b0, 1'b1, 8'hA3});
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, BIT);
    exp_b_q.push_back({1'b0, 1'b0, 8'hA3});
    send_frame(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    chk("t3_valid_count", 32'(valid_b_cnt), 32'd2);

    // 4: framing error, flag held, then cleared by a good frame
    exp_a_q.push_back({1'b1, 1'b0, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, BIT);
    drive_bit(1'b0, 1'b1, 2 * BIT);
    chk("t4_ferr_held", 32'(if_a.o_frame_error), 32'h1);
    chk("t4_data_held", 32'(if_a.o_data), 32'h3C);
    exp_a_q.push_back({1'b0, 1'b0, 8'h81});
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    chk("t4_ferr_cleared", 32'(if_a.o_frame_error), 32'h0);

    // 5: break, exactly one pulse and no character
    v0 = valid_a_cnt;
    b0 = brk_a_cnt;
    drive_bit(1'b0, 1'b0, 12 * BIT);
    drive_bit(1'b0, 1'b1, 2 * BIT);
    chk("t5_one_break", 32'(brk_a_cnt), 32'(b0 + 1));
    chk("t5_no_valid", 32'(valid_a_cnt), 32'(v0));
    exp_a_q.push_back({1'b0, 1'b0, 8'h7E});
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, BIT);
    repeat (2 * BIT) @(negedge clk);
    chk("t5_data_after", 32'(if_a.o_data), 32'h7E);

    // 6: reset mid-frame, then clean frame and +/-3 % bit rates
    partial = 8'hF0;
    drive_bit(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, partial[i], BIT);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_data",  32'(if_a.o_data), 32'h0);
    chk("t6_rst_valid", 32'(if_a.o_data_valid), 32'h0);
    chk("t6_rst_ferr",  32'(if_a.o_frame_error), 32'h0);
    chk("t6_rst_state", 32'(if_a.o_dbg_state), 32'(RX_IDLE));
    @(negedge clk);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    exp_a_q.push_back({1'b0, 1'b0, 8'h0F});
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, BIT);
    exp_a_q.push_back({1'b0, 1'b0, 8'h5A});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 165);
    exp_a_q.push_back({1'b0, 1'b0, 8'hC3});
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 155);
    drive_bit(1'b0, 1'b1, 2 * BIT);

    // Drain with a bounded wait
    for (int i = 0; i < 4000 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
      @(negedge clk);
    chk("end_queue_a_empty", 32'(exp_a_q.size()), 32'd0);
    chk("end_queue_b_empty", 32'(exp_b_q.size()), 32'd0);
    chk("end_break_a", 32'(brk_a_cnt), 32'd1);
    chk("end_break_b", 32'(brk_b_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
